// File: rtl/counter_checker.sv
// Receive-side checker for a free-running 32-bit counter stream.
// Acquires lock after a run of good samples, then counts discontinuities.
module counter_checker #(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      expected
);

  typedef enum logic [1:0] {
    UNLOCKED,
    CHECKING,
    LOCKED
  } state_t;

  localparam logic [7:0] LOCK_N = 8'(LOCK_CNT);

  state_t     state;
  logic [7:0] run_cnt;
  logic       match;
  logic [7:0] run_nxt;

  assign match   = (in_data == expected);
  assign run_nxt = run_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= UNLOCKED;
      run_cnt    <= 8'd0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      expected   <= 32'd0;
    end else begin
      err_pulse <= 1'b0;
      if (clr_err) begin
        err_count  <= '0;
        err_sticky <= 1'b0;
      end
      if (in_valid) begin
        // Always resync to the received stream, match or not.
        expected <= in_data + 32'd1;
        unique case (state)
          UNLOCKED: begin
            run_cnt <= 8'd0;
            state   <= CHECKING;
          end
          CHECKING: begin
            if (match) begin
              run_cnt <= run_nxt;
              if (run_nxt == LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              run_cnt <= 8'd0;
            end
          end
          LOCKED: begin
            if (!match) begin
              err_pulse  <= 1'b1;
              err_sticky <= 1'b1;
              run_cnt    <= 8'd0;
              state      <= CHECKING;
              locked     <= 1'b0;
              // A clear in the same cycle must not lose this error.
              if (clr_err)
                err_count <= {{(ERR_W-1){1'b0}}, 1'b1};
              else if (err_count != '1)
                err_count <= err_count + 1'b1;
            end
          end
          default: begin
            run_cnt <= 8'd0;
            state   <= UNLOCKED;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/counter_checker.md
# counter_checker

Receive-side checker for the free-running 32-bit counter stream. It samples a counter value each time `in_valid` is high and verifies that each sample equals the previous sample plus one, modulo 2^32. It acquires lock after a run of consecutive good samples, then reports and counts every discontinuity. It sits downstream of the counter in bring-up and link-test designs, as the reader for the counter's writer.

## Interface
- `LOCK_CNT`, default 4: number of consecutive matching samples after the seed sample that are required to declare lock. Range 1..255.
- `ERR_W`, default 16: width of the error counter.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_data` is valid this cycle.
- `in_data` input 32: received counter value.
- `clr_err` input 1: one-cycle request to clear `err_sticky` and `err_count`.
- `locked` output 1: checker is in the LOCKED state.
- `err_pulse` output 1: one-cycle pulse for each mismatch detected while locked.
- `err_sticky` output 1: set by any `err_pulse`; held until `clr_err` or `rst`.
- `err_count` output ERR_W: number of mismatches while locked; saturates at all-ones.
- `expected` output 32: value the next valid sample must carry.

## Operation
- **States:**
  - UNLOCKED: no reference value is held.
  - CHECKING: a reference value is held and a run of good samples is being counted toward lock.
  - LOCKED: the stream is verified and mismatches are reported.
- **Match rule:** a sample matches when `in_data == expected`. After every valid sample, `expected` becomes `in_data + 1` (32-bit wrap), whether or not the sample matched, so the checker always resynchronises to the received stream.
- **Wrap-around:** `expected = 0xFFFFFFFF` followed by `in_data = 0x00000000` is a match.
- **Run counter:** internal, 8 bits wide.
- **UNLOCKED:**
  - On a valid sample: seed `expected`, clear the run counter, and go to CHECKING.
  - No error is ever reported from this state.
- **CHECKING:**
  - Valid match: increment the run counter. When the run counter reaches LOCK_CNT, go to LOCKED.
  - Valid mismatch: reseed `expected`, clear the run counter, stay in CHECKING, and report no error.
- **LOCKED:**
  - Valid match: no action.
  - Valid mismatch: assert `err_pulse`, set `err_sticky`, increment `err_count` (saturating), clear the run counter, and go to CHECKING.
- **Gaps:** when `in_valid` is low, state, `expected` and all counters hold and nothing is checked. Gaps never cause errors.
- **`clr_err` alone:** sets `err_count` to 0 and `err_sticky` to 0. It does not affect lock state or `expected`.
- **`clr_err` with a new error in the same cycle:** `err_count` becomes 1, `err_sticky` stays 1, and `err_pulse` is asserted. The new error is never lost.
- **`err_count` saturation:** at all-ones, further errors still pulse `err_pulse` but leave the count unchanged.

## Timing
- **Outputs:** all outputs are registered, with one-cycle latency. A sample on edge N is reflected in the outputs after edge N.
- **Reset values:**
  - `locked` = 0
  - `err_pulse` = 0
  - `err_sticky` = 0
  - `err_count` = 0
  - `expected` = 0
  - state = UNLOCKED
  - run counter = 0
- **Reset mid-operation:** `rst` high on any edge forces the reset values on that edge and overrides `in_valid` and `clr_err`. After reset, the first valid sample is a seed.
- **Lock latency:** with a gap-free, correct stream, `locked` rises after edge LOCK_CNT+1 counted from the seed sample. At the default LOCK_CNT = 4, that is the 5th valid sample.
- **`err_pulse`:** high for exactly one cycle per erroneous sample. Back-to-back bad samples in LOCKED give only one pulse, because the first mismatch drops the checker to CHECKING.
- **`locked` on error:** falls on the same edge that raises `err_pulse`.
- **Throughput:** one sample per cycle, with no backpressure.

## Test plan
- **Reset and lock:** reset, then valid samples 100, 101, …, 104 with LOCK_CNT = 4. Required: `locked` = 0 through the 4th sample, `locked` = 1 after the 5th, `expected` = 105, `err_count` = 0.
- **Wrap-around:** lock on 0xFFFFFFFD, 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1, then continue with 0x2. Required: no `err_pulse`, `locked` stays 1, `expected` = 0x3.
- **Single error:** while locked, inject 200 in place of the expected 50, then continue 201, 202, …. Required: one `err_pulse`, `err_count` = 1, `err_sticky` = 1, `locked` = 0, then relock after 4 matches starting from 201, with `err_sticky` still 1.
- **Gaps and clear:** while locked, hold `in_valid` low for 10 cycles, then resume with the correct value. Required: no error. Then assert `clr_err` in the same cycle as a mismatch. Required: `err_count` = 1, `err_sticky` = 1.
- **Saturation:** with ERR_W = 2, force 5 lock/mismatch cycles. Required: `err_count` = 3, and `err_pulse` seen 5 times.
- **Reset mid-run:** assert `rst` for one cycle while locked with `err_count` = 2 and `in_valid` high. Required: all outputs return to their reset values, and the next sample seeds without raising an error.
